reg_file_sb: RTL

//  Parametrised multi-read-port integer register file with a per-register pending (scoreboard) bit.

---
 rtl/reg_file_sb_pkg.sv | 19 +
 rtl/reg_file_sb_if.sv | 29 ++
 rtl/reg_file_sb_scoreboard.sv | 92 +++++++++
 rtl/reg_file_sb.sv | 77 +++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared types and constants for the scoreboarded register file.
package regfile_pkg;

    localparam int RF_REG_SIZE   = 32;
    localparam int RF_ADDR_BITS  = 5;
    localparam int RF_READ_PORTS = 2;
    localparam int RF_DEPTH      = 2 ** RF_ADDR_BITS;

    typedef logic        [RF_ADDR_BITS-1:0] rf_addr_t;
    typedef logic signed [RF_REG_SIZE-1:0]  rf_data_t;

    localparam rf_addr_t RF_ZERO_ADDR = 5'd0;

    typedef enum logic {
        SB_FREE = 1'b0,
        SB_PEND = 1'b1
    } sb_state_e;

endpackage

// File: rtl/reg_file_sb_if.sv
// Issue/writeback/read bus between the core pipeline (master) and the register file (slave).
interface reg_file_sb_if #(
    parameter int Reg_size   = regfile_pkg::RF_REG_SIZE,
    parameter int Addr_bits  = regfile_pkg::RF_ADDR_BITS,
    parameter int Read_ports = regfile_pkg::RF_READ_PORTS
) ();

    logic [Read_ports-1:0][Addr_bits-1:0] rd_addr;
    logic [Read_ports-1:0][Reg_size-1:0]  rd_data;
    logic [Read_ports-1:0]                rd_busy;
    logic                                 wr_en;
    logic [Addr_bits-1:0]                 wr_addr;
    logic [Reg_size-1:0]                  wr_data;
    logic                                 rsv_en;
    logic [Addr_bits-1:0]                 rsv_addr;
    logic                                 rsv_ok;
    logic [(2**Addr_bits)-1:0]            busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, rsv_ok, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, rsv_ok, busy_vec
    );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one FREE/PEND state per register, reservation grant and
// the rule that a same-cycle reservation beats a same-cycle writeback release.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter  int Addr_bits = RF_ADDR_BITS,
    localparam int Depth     = 2 ** Addr_bits
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [Addr_bits-1:0] wr_addr,
    input  logic                 rsv_en,
    input  logic [Addr_bits-1:0] rsv_addr,
    output logic                 rsv_ok,
    output logic [Depth-1:0]     busy_vec
);

    localparam logic [Addr_bits-1:0] ZERO_ADDR = Addr_bits'(RF_ZERO_ADDR);

    sb_state_e state_r     [Depth];
    sb_state_e state_nxt_s [Depth];
    logic      grant_s;

    // Reservation grant: x0 always, a free target, or a pending target released this cycle.
    always_comb begin
        grant_s = 1'b0;
        if (!rsv_en) begin
            grant_s = 1'b0;
        end else if (rsv_addr == ZERO_ADDR) begin
            grant_s = 1'b1;
        end else if (state_r[rsv_addr] != SB_PEND) begin
            grant_s = 1'b1;
        end else if (wr_en && (wr_addr == rsv_addr)) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign rsv_ok = grant_s;

    // Per-register next state; x0 is pinned FREE.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            state_nxt_s[i] = state_r[i];
            if (i == 0) begin
                state_nxt_s[i] = SB_FREE;
            end else begin
                case (state_r[i])
                    SB_FREE: begin
                        if (grant_s && (rsv_addr == Addr_bits'(i))) begin
                            state_nxt_s[i] = SB_PEND;
                        end else begin
                            state_nxt_s[i] = SB_FREE;
                        end
                    end
                    SB_PEND: begin
                        if (grant_s && (rsv_addr == Addr_bits'(i))) begin
                            state_nxt_s[i] = SB_PEND;
                        end else if (wr_en && (wr_addr == Addr_bits'(i))) begin
                            state_nxt_s[i] = SB_FREE;
                        end else begin
                            state_nxt_s[i] = SB_PEND;
                        end
                    end
                    default: state_nxt_s[i] = SB_FREE;
                endcase
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Depth; i++) begin
            if (!rst_n) begin
                state_r[i] <= SB_FREE;
            end else begin
                state_r[i] <= state_nxt_s[i];
            end
        end
    end

    // Flatten states into the externally visible pending vector.
    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < Depth; i++) begin
            busy_vec[i] = (state_r[i] == SB_PEND);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with per-register pending bits.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter  int Reg_size   = RF_REG_SIZE,
    parameter  int Addr_bits  = RF_ADDR_BITS,
    parameter  int Read_ports = RF_READ_PORTS,
    localparam int Depth      = 2 ** Addr_bits
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_sb_if.slave bus
);

    localparam logic [Addr_bits-1:0] ZERO_ADDR = Addr_bits'(RF_ZERO_ADDR);

    logic [Reg_size-1:0]                 regs_r [Depth];
    logic [Depth-1:0]                    busy_s;
    logic                                wr_live_s;
    logic [Read_ports-1:0][Reg_size-1:0] rd_data_s;
    logic [Read_ports-1:0]               rd_busy_s;

    rf_scoreboard #(
        .Addr_bits (Addr_bits)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .rsv_ok   (bus.rsv_ok),
        .busy_vec (busy_s)
    );

    assign wr_live_s = bus.wr_en && (bus.wr_addr != ZERO_ADDR);

    // Data array: reset clears every entry; x0 is never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_live_s) begin
            regs_r[bus.wr_addr] <= bus.wr_data;
        end else begin
            regs_r[bus.wr_addr] <= regs_r[bus.wr_addr];
        end
    end

    // Independent combinational read ports.
    always_comb begin
        rd_data_s = '0;
        rd_busy_s = '0;
        for (int p = 0; p < Read_ports; p++) begin
            if (bus.rd_addr[p] == ZERO_ADDR) begin
                rd_data_s[p] = '0;
                rd_busy_s[p] = 1'b0;
`ifdef RF_BYPASS_EN
            end else if (wr_live_s && (bus.rd_addr[p] == bus.wr_addr)) begin
                rd_data_s[p] = bus.wr_data;
                rd_busy_s[p] = 1'b0;
`endif
            end else begin
                rd_data_s[p] = regs_r[bus.rd_addr[p]];
                rd_busy_s[p] = busy_s[bus.rd_addr[p]];
            end
        end
    end

    assign bus.rd_data  = rd_data_s;
    assign bus.rd_busy  = rd_busy_s;
    // The pending vector always shows stored state, even with forwarding enabled.
    assign bus.busy_vec = busy_s;

endmodule
